// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - skews A/B K-step vectors into a systolic array and tracks completion
// Optional WAIT timeout guarded by SYS_FEED_TIMEOUT_EN.
module systolic_feeder #(
  parameter int WIDTH      = 16,
  parameter int ARR_HEIGHT = 4,
  parameter int ARR_WIDTH  = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_last,
  input  logic [ARR_HEIGHT*WIDTH-1:0] in_a_vec,
  input  logic [ARR_WIDTH*WIDTH-1:0]  in_b_vec,
  output logic [ARR_HEIGHT*WIDTH-1:0] sys_in_a,
  output logic [ARR_WIDTH*WIDTH-1:0]  sys_in_b,
  output logic                        sys_done_flag,
  input  logic                        sys_calc_done,
  output logic                        busy,
  output logic                        result_valid,
  output logic                        timeout_err
);

  typedef enum logic [1:0] {IDLE, FEED, WAIT} state_t;

  state_t state;
  logic   fire;

  assign in_ready = (state != WAIT);
  assign busy     = (state != IDLE);
  assign fire     = in_valid && in_ready;

  // Lane i gets a chain of depth i+1; idle cycles push zero bubbles.
  for (genvar i = 0; i < ARR_HEIGHT; i++) begin : g_a_lane
    logic [WIDTH-1:0] sr [0:i];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) sr[k] <= '0;
      end else begin
        sr[0] <= fire ? in_a_vec[i*WIDTH +: WIDTH] : '0;
        for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
      end
    end
    assign sys_in_a[i*WIDTH +: WIDTH] = sr[i];
  end

  for (genvar j = 0; j < ARR_WIDTH; j++) begin : g_b_lane
    logic [WIDTH-1:0] sr [0:j];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k <= j; k++) sr[k] <= '0;
      end else begin
        sr[0] <= fire ? in_b_vec[j*WIDTH +: WIDTH] : '0;
        for (int k = 1; k <= j; k++) sr[k] <= sr[k-1];
      end
    end
    assign sys_in_b[j*WIDTH +: WIDTH] = sr[j];
  end

`ifdef SYS_FEED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      sys_done_flag <= 1'b0;
      result_valid  <= 1'b0;
`ifdef SYS_FEED_TIMEOUT_EN
      wait_cnt      <= '0;
      timeout_err   <= 1'b0;
`endif
    end else begin
      // Lane-0 of the final vector becomes visible on the same edge as this flag.
      sys_done_flag <= fire && in_last;
      result_valid  <= 1'b0;
      case (state)
        IDLE, FEED: begin
`ifdef SYS_FEED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          if (fire) state <= in_last ? WAIT : FEED;
        end
        WAIT: begin
          if (sys_calc_done) begin
            state        <= IDLE;
            result_valid <= 1'b1;
          end
`ifdef SYS_FEED_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// tb/tb_systolic_feeder.sv - table-driven bench for systolic_feeder
module tb_systolic_feeder;
  localparam int W  = 16;
  localparam int H  = 4;
  localparam int WD = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready, in_last;
  logic [H*W-1:0]  in_a_vec, sys_in_a;
  logic [WD*W-1:0] in_b_vec, sys_in_b;
  logic            sys_done_flag, sys_calc_done, busy, result_valid, timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.WIDTH(W), .ARR_HEIGHT(H), .ARR_WIDTH(WD), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_a_vec(in_a_vec), .in_b_vec(in_b_vec), .sys_in_a(sys_in_a), .sys_in_b(sys_in_b),
    .sys_done_flag(sys_done_flag), .sys_calc_done(sys_calc_done), .busy(busy),
    .result_valid(result_valid), .timeout_err(timeout_err)
  );

  typedef struct {
    logic v, l, cd;
    int   k;
    int   s0, s1, s2, s3;
    logic rdy, dn, bsy, rv;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Vector k: A lane i = k*0x100 + i + 1, B lane j = 0xB000 + k*0x10 + j; k = 0 is a bubble.
  function automatic logic [63:0] va(input int k);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = (k == 0) ? 16'h0 : 16'(k*256 + i + 1);
    return r;
  endfunction

  function automatic logic [63:0] vb(input int k);
    logic [63:0] r;
    for (int j = 0; j < 4; j++) r[j*16 +: 16] = (k == 0) ? 16'h0 : 16'(16'hB000 + k*16 + j);
    return r;
  endfunction

  // Builds the expected lane contents given which vector index sits on each lane.
  function automatic logic [63:0] lanes(input bit is_b, input int k0, k1, k2, k3);
    int ks[4];
    logic [63:0] r, t;
    ks = '{k0, k1, k2, k3};
    r  = '0;
    for (int i = 0; i < 4; i++) begin
      t = is_b ? vb(ks[i]) : va(ks[i]);
      r[i*16 +: 16] = t[i*16 +: 16];
    end
    return r;
  endfunction

  initial begin
    //              v  l  cd k   lane0..3      rdy dn bsy rv
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 2, 2, 1, 0, 0, 1, 0, 1, 0});
    tbl.push_back('{1, 1, 0, 3, 3, 2, 1, 0, 0, 1, 1, 0});
    tbl.push_back('{1, 0, 0, 7, 0, 3, 2, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 7, 0, 0, 3, 2, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{1, 0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0});
    tbl.push_back('{1, 0, 0, 2, 2, 0, 0, 1, 1, 0, 1, 0});
    tbl.push_back('{1, 1, 0, 3, 3, 2, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 3, 2, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 3, 2, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{1, 1, 0, 4, 4, 0, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 1, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0});

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; sys_calc_done = 1'b0;
    in_a_vec = '0; in_b_vec = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d a", c), sys_in_a, 64'h0);
      chk($sformatf("idle%0d b", c), sys_in_b, 64'h0);
      chk($sformatf("idle%0d flags", c),
          {60'h0, sys_done_flag, busy, result_valid, timeout_err}, 64'h0);
      chk($sformatf("idle%0d ready", c), in_ready, 64'h1);
    end

    for (int r = 0; r < tbl.size(); r++) begin
      in_valid = tbl[r].v; in_last = tbl[r].l; sys_calc_done = tbl[r].cd;
      in_a_vec = va(tbl[r].k); in_b_vec = vb(tbl[r].k);
      @(negedge clk);
      chk($sformatf("row%0d a", r), sys_in_a, lanes(0, tbl[r].s0, tbl[r].s1, tbl[r].s2, tbl[r].s3));
      chk($sformatf("row%0d b", r), sys_in_b, lanes(1, tbl[r].s0, tbl[r].s1, tbl[r].s2, tbl[r].s3));
      chk($sformatf("row%0d ready", r), in_ready, tbl[r].rdy);
      chk($sformatf("row%0d done", r), sys_done_flag, tbl[r].dn);
      chk($sformatf("row%0d busy", r), busy, tbl[r].bsy);
      chk($sformatf("row%0d rv", r), result_valid, tbl[r].rv);
      chk($sformatf("row%0d terr", r), timeout_err, 1'b0);
    end
    in_valid = 1'b0; in_last = 1'b0; sys_calc_done = 1'b0;

    // Mid-operation reset aborts the product.
    in_valid = 1'b1; in_a_vec = va(5); in_b_vec = vb(5);
    @(negedge clk);
    in_a_vec = va(6); in_b_vec = vb(6);
    @(negedge clk);
    chk("pre_abort a", sys_in_a, lanes(0, 6, 5, 0, 0));
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort a", sys_in_a, 64'h0);
    chk("abort b", sys_in_b, 64'h0);
    chk("abort busy", busy, 1'b0);
    chk("abort ready", in_ready, 1'b1);
    for (int c = 0; c < 6; c++) begin
      sys_calc_done = (c == 2);
      @(negedge clk);
      chk($sformatf("post_abort%0d done", c), sys_done_flag, 1'b0);
      chk($sformatf("post_abort%0d rv", c), result_valid, 1'b0);
      chk($sformatf("post_abort%0d a", c), sys_in_a, 64'h0);
    end
    sys_calc_done = 1'b0;

    in_valid = 1'b1; in_last = 1'b1; in_a_vec = va(1); in_b_vec = vb(1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
`ifdef SYS_FEED_TIMEOUT_EN
    for (int n = 1; n <= TO; n++) begin
      @(negedge clk);
      chk($sformatf("timeout n%0d", n), timeout_err, (n == TO));
    end
    chk("timeout ready", in_ready, 1'b1);
    chk("timeout busy", busy, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("timeout sticky%0d", c), timeout_err, 1'b1);
      chk($sformatf("timeout rv%0d", c), result_valid, 1'b0);
    end
`else
    for (int n = 0; n < 12; n++) @(negedge clk);
    chk("long wait busy", busy, 1'b1);
    chk("long wait ready", in_ready, 1'b0);
    chk("long wait terr", timeout_err, 1'b0);
    sys_calc_done = 1'b1;
    @(negedge clk);
    sys_calc_done = 1'b0;
    chk("long wait rv", result_valid, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
Transmit-side companion to the buffered systolic array. It accepts one K-step at a time over a valid/ready stream: an A column vector (ARR_HEIGHT lanes) and a B row vector (ARR_WIDTH lanes). It applies the triangular skew the array needs and drives the array's west/north inputs and its done flag. It then waits for the array's calc-done pulse and reports the result as ready to the controller.

Parameters:
WIDTH, 16, element width in bits
ARR_HEIGHT, 4, number of A lanes (array rows)
ARR_WIDTH, 4, number of B lanes (array columns)
TIMEOUT, 64, WAIT-state cycle limit (used only with the optional feature)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  K-step vector valid
in_ready  output  1  feeder can accept a vector
in_last  input  1  marks the final K-step of the matrix product
in_a_vec  input  ARR_HEIGHT*WIDTH  A column; lane i = bits [i*WIDTH +: WIDTH]
in_b_vec  input  ARR_WIDTH*WIDTH  B row; lane j = bits [j*WIDTH +: WIDTH]
sys_in_a  output  ARR_HEIGHT*WIDTH  skewed west data to the array
sys_in_b  output  ARR_WIDTH*WIDTH  skewed north data to the array
sys_done_flag  output  1  one-cycle pulse to the array's done input
sys_calc_done  input  1  calc-done pulse from the array
busy  output  1  high in FEED and WAIT
result_valid  output  1  one-cycle pulse: the array's out_c holds the final result
timeout_err  output  1  sticky error flag (optional feature)

Behaviour:
- One clock (clk); reset is synchronous and active-high. On reset: state=IDLE; all skew registers cleared; sys_in_a=0, sys_in_b=0, sys_done_flag=0, result_valid=0, busy=0, timeout_err=0.
- Transfer happens when in_valid && in_ready at a rising edge. in_ready=1 in IDLE and FEED, 0 in WAIT.
- Skew: A lane i and B lane j pass through shift chains of depth i+1 and j+1 respectively, all registered. A vector accepted at edge t appears:
  - on A lane i in cycle t+1+i;
  - on B lane j in cycle t+1+j.
- Bubble insertion: any cycle without a transfer pushes zeros into every chain head. A zero bubble contributes 0*0 to each PE, so gaps in in_valid are legal.
- FSM:
  - IDLE: transfer with in_last=0 -> FEED. Transfer with in_last=1 -> WAIT (single K-step product).
  - FEED: transfer with in_last=1 -> WAIT. Otherwise stay in FEED.
  - WAIT: sys_calc_done=1 -> IDLE, and result_valid pulses the following cycle.
- sys_done_flag is high for exactly one cycle, in the cycle the last vector's lane-0 elements appear (edge t_last+1).
- The skew chains keep shifting in WAIT and drain with zeros; the last lane empties after max(ARR_HEIGHT,ARR_WIDTH) cycles.
- sys_calc_done is ignored in IDLE and FEED.
- A new product may start in the cycle after result_valid.
- Reset asserted mid-operation aborts immediately: chains are flushed to zero and no result_valid or sys_done_flag is issued.
- Data is passed bit-exact; the feeder performs no arithmetic. Inputs held while in_ready=0 are not consumed.

Optional Feature:
Macro SYS_FEED_TIMEOUT_EN.
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT before sys_calc_done arrives:
  - timeout_err is set and stays high until reset;
  - the FSM returns to IDLE;
  - no result_valid is issued.
- Undefined: no counter is built; timeout_err is tied to 0 and WAIT lasts indefinitely.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, in_ready=1, busy=0.
- 4x4, WIDTH=16. Send K=3 vectors back-to-back with A lanes = 0x0001..0x0004, the last one with in_last=1:
  - A lane 0 shows 0x0001 one cycle after its transfer; A lane 3 shows 0x0004 four cycles after its transfer;
  - sys_done_flag pulses once, in the cycle after the third transfer;
  - in_ready=0 from that cycle on.
- Same stream with in_valid dropped for 2 cycles mid-stream -> exactly 2 zero slots appear on every lane, each delayed by its lane's skew.
- In WAIT, pulse sys_calc_done -> result_valid=1 for exactly one cycle on the next cycle; state returns to IDLE; in_ready=1.
- Assert reset 2 cycles after the first transfer -> all chains read 0 next cycle; no sys_done_flag and no result_valid follow.
- With SYS_FEED_TIMEOUT_EN and TIMEOUT=8, never pulse sys_calc_done -> timeout_err rises 8 cycles after entering WAIT and stays high; in_ready=1; result_valid stays 0.
